// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA bus definition: field layout, default 1024x768@60 timing and colours.
// Every stage that produces or consumes the VGA bus imports this package.
`timescale 1ns/1ps
package vga_timing_gen_pkg;

    localparam int VGA_CNT_W    = 11;
    localparam int VGA_RGB_W    = 12;
    localparam int VGA_BUS_SIZE = 4 + 2 * VGA_CNT_W + VGA_RGB_W;

    // The field order is fixed.
    typedef struct packed {
        logic                 vs;
        logic                 hs;
        logic                 vblnk;
        logic                 hblnk;
        logic [VGA_CNT_W-1:0] hcount;
        logic [VGA_CNT_W-1:0] vcount;
        logic [VGA_RGB_W-1:0] rgb;
    } vga_bus_t;

    localparam int unsigned H_ACTIVE_DEF = 1024;
    localparam int unsigned H_FP_DEF     = 24;
    localparam int unsigned H_SYNC_DEF   = 136;
    localparam int unsigned H_BP_DEF     = 160;
    localparam int unsigned V_ACTIVE_DEF = 768;
    localparam int unsigned V_FP_DEF     = 3;
    localparam int unsigned V_SYNC_DEF   = 6;
    localparam int unsigned V_BP_DEF     = 29;

    localparam logic [VGA_RGB_W-1:0] RGB_BLACK = 12'h000;
    localparam logic [VGA_RGB_W-1:0] RGB_WHITE = 12'hfff;
    localparam logic [VGA_RGB_W-1:0] RGB_RED   = 12'hf00;
    localparam logic [VGA_RGB_W-1:0] RGB_GREEN = 12'h0f0;
    localparam logic [VGA_RGB_W-1:0] RGB_BLUE  = 12'h00f;

endpackage

// File: rtl/vga_timing_gen_if.sv
// VGA bus plus frame/line strobes.
// The timing generator drives the master side and the draw stages read the slave side.
`timescale 1ns/1ps
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    vga_bus_t vga_out;
    logic     frame_start;
    logic     line_start;

    modport master (output vga_out, output frame_start, output line_start);
    modport slave  (input  vga_out, input  frame_start, input  line_start);

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter with blank and sync region flags.
// The flags are registered from count_next, so they change on the same edge as count.
`timescale 1ns/1ps
module vga_axis_counter #(
    parameter int unsigned TOTAL      = 1344,
    parameter int unsigned ACTIVE     = 1024,
    parameter int unsigned SYNC_START = 1048,
    parameter int unsigned SYNC_LEN   = 136
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        tick,
    output logic [10:0] count,
    output logic        blnk,
    output logic        sync,
    output logic        wrap
);

    localparam logic [10:0] LAST    = 11'(TOTAL - 1);
    localparam logic [10:0] ACT     = 11'(ACTIVE);
    localparam logic [10:0] SYNC_LO = 11'(SYNC_START);
    localparam logic [10:0] SYNC_HI = 11'(SYNC_START + SYNC_LEN);

    logic [10:0] count_reg, count_next;
    logic        blnk_reg, sync_reg;

    // Wrap on an explicit compare so the count never runs past TOTAL-1.
    assign wrap = tick && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (wrap) begin
            count_next = '0;
        end else if (tick) begin
            count_next = count_reg + 11'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            count_reg <= '0;
            blnk_reg  <= 1'b0;
            sync_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            blnk_reg  <= (count_next >= ACT);
            sync_reg  <= (count_next >= SYNC_LO) && (count_next < SYNC_HI);
        end
    end

    assign count = count_reg;
    assign blnk  = blnk_reg;
    assign sync  = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: drives the VGA bus with counters, blanking and sync and with rgb=0.
// It also drives the frame and line start strobes.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             pclk,
    input  logic             rst,
    vga_timing_gen_if.master vga_if
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [10:0] h_count, v_count;
    logic        h_blnk, h_sync, h_wrap;
    logic        v_blnk, v_sync, v_wrap_unused;
    vga_bus_t    bus;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
    ) u_h_axis (
        .pclk(pclk), .rst(rst), .tick(1'b1),
        .count(h_count), .blnk(h_blnk), .sync(h_sync), .wrap(h_wrap)
    );

    // The vertical axis steps once per line, so vs moves with hcount=0.
    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
    ) u_v_axis (
        .pclk(pclk), .rst(rst), .tick(h_wrap),
        .count(v_count), .blnk(v_blnk), .sync(v_sync), .wrap(v_wrap_unused)
    );

    always_comb begin
        bus        = '0;
        bus.vs     = v_sync ? SYNC_POL : ~SYNC_POL;
        bus.hs     = h_sync ? SYNC_POL : ~SYNC_POL;
        bus.vblnk  = v_blnk;
        bus.hblnk  = h_blnk;
        bus.hcount = h_count;
        bus.vcount = v_count;
        bus.rgb    = RGB_BLACK;
    end

    assign vga_if.vga_out     = bus;
    // The strobes decode the counter state, so they are also high during reset.
    assign vga_if.line_start  = (h_count == 11'd0);
    assign vga_if.frame_start = (h_count == 11'd0) && (v_count == 11'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 1024x768 instance checks the horizontal landmarks.
// A scaled 25x13 instance covers the vertical sweep, reset, frame period and bus checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    logic pclk = 1'b0;
    logic rst_s, rst_d;
    always #7 pclk = ~pclk;

    vga_timing_gen_if s_if ();
    vga_timing_gen_if d_if ();

    // Scaled timing: H 16/2/4/3 (total 25, hs low 18..21), V 8/1/2/2 (total 13, vs low 9..10).
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
    ) dut_s (.pclk(pclk), .rst(rst_s), .vga_if(s_if));

    vga_timing_gen dut_d (.pclk(pclk), .rst(rst_d), .vga_if(d_if));

    // This stage copies the bus into a register, like a draw stage that changes nothing.
    vga_bus_t pipe_bus;
    always_ff @(posedge pclk) pipe_bus <= s_if.vga_out;

    typedef struct {
        int          n;
        logic        rst;
        logic [10:0] hc, vc;
        logic        hb, vb, hs, vs, fs, ls;
    } vec_t;

    int passed = 0;
    int total  = 0;

    function automatic logic [39:0] exp_word(input logic [10:0] hc, input logic [10:0] vc,
                                             input logic hb, input logic vb, input logic hs,
                                             input logic vs, input logic fs, input logic ls);
        vga_bus_t b;
        b.vs = vs; b.hs = hs; b.vblnk = vb; b.hblnk = hb;
        b.hcount = hc; b.vcount = vc; b.rgb = 12'h000;
        return {b, fs, ls};
    endfunction

    function automatic logic [39:0] vec_word(input vec_t v);
        return exp_word(v.hc, v.vc, v.hb, v.vb, v.hs, v.vs, v.fs, v.ls);
    endfunction

    // Expected output of the scaled instance at position p, where p counts edges after reset.
    function automatic logic [39:0] model_s(input int p);
        int hc, vc;
        hc = p % 25;
        vc = (p / 25) % 13;
        return exp_word(11'(hc), 11'(vc), hc >= 16, vc >= 8, !(hc >= 18 && hc < 22),
                        !(vc >= 9 && vc < 11), hc == 0 && vc == 0, hc == 0);
    endfunction

    task automatic check_word(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got bus/fs/ls=%h, expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [39:0] s_word();
        return {s_if.vga_out, s_if.frame_start, s_if.line_start};
    endfunction

    function automatic logic [39:0] d_word();
        return {d_if.vga_out, d_if.frame_start, d_if.line_start};
    endfunction

    vec_t d_tab[11];
    vec_t s_tab[21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int sweep_err, pipe_err, rgb_err, bad_p, cnt;
        logic [39:0] exp_now, exp_prev;

        // Fields: n, rst, hcount, vcount, hblnk, vblnk, hs, vs, frame_start, line_start
        d_tab[0]  = '{5,    1'b1, 11'd0,    11'd0, 0, 0, 1, 1, 1, 1};
        d_tab[1]  = '{1,    1'b0, 11'd1,    11'd0, 0, 0, 1, 1, 0, 0};
        d_tab[2]  = '{1022, 1'b0, 11'd1023, 11'd0, 0, 0, 1, 1, 0, 0};
        d_tab[3]  = '{1,    1'b0, 11'd1024, 11'd0, 1, 0, 1, 1, 0, 0};
        d_tab[4]  = '{23,   1'b0, 11'd1047, 11'd0, 1, 0, 1, 1, 0, 0};
        d_tab[5]  = '{1,    1'b0, 11'd1048, 11'd0, 1, 0, 0, 1, 0, 0};
        d_tab[6]  = '{135,  1'b0, 11'd1183, 11'd0, 1, 0, 0, 1, 0, 0};
        d_tab[7]  = '{1,    1'b0, 11'd1184, 11'd0, 1, 0, 1, 1, 0, 0};
        d_tab[8]  = '{159,  1'b0, 11'd1343, 11'd0, 1, 0, 1, 1, 0, 0};
        d_tab[9]  = '{1,    1'b0, 11'd0,    11'd1, 0, 0, 1, 1, 0, 1};
        d_tab[10] = '{1,    1'b0, 11'd1,    11'd1, 0, 0, 1, 1, 0, 0};

        s_tab[0]  = '{5,   1'b1, 11'd0,  11'd0,  0, 0, 1, 1, 1, 1};
        s_tab[1]  = '{1,   1'b0, 11'd1,  11'd0,  0, 0, 1, 1, 0, 0};
        s_tab[2]  = '{14,  1'b0, 11'd15, 11'd0,  0, 0, 1, 1, 0, 0};
        s_tab[3]  = '{1,   1'b0, 11'd16, 11'd0,  1, 0, 1, 1, 0, 0};
        s_tab[4]  = '{1,   1'b0, 11'd17, 11'd0,  1, 0, 1, 1, 0, 0};
        s_tab[5]  = '{1,   1'b0, 11'd18, 11'd0,  1, 0, 0, 1, 0, 0};
        s_tab[6]  = '{3,   1'b0, 11'd21, 11'd0,  1, 0, 0, 1, 0, 0};
        s_tab[7]  = '{1,   1'b0, 11'd22, 11'd0,  1, 0, 1, 1, 0, 0};
        s_tab[8]  = '{2,   1'b0, 11'd24, 11'd0,  1, 0, 1, 1, 0, 0};
        s_tab[9]  = '{1,   1'b0, 11'd0,  11'd1,  0, 0, 1, 1, 0, 1};
        s_tab[10] = '{1,   1'b0, 11'd1,  11'd1,  0, 0, 1, 1, 0, 0};
        s_tab[11] = '{173, 1'b0, 11'd24, 11'd7,  1, 0, 1, 1, 0, 0};
        s_tab[12] = '{1,   1'b0, 11'd0,  11'd8,  0, 1, 1, 1, 0, 1};
        s_tab[13] = '{25,  1'b0, 11'd0,  11'd9,  0, 1, 1, 0, 0, 1};
        s_tab[14] = '{18,  1'b0, 11'd18, 11'd9,  1, 1, 0, 0, 0, 0};
        s_tab[15] = '{7,   1'b0, 11'd0,  11'd10, 0, 1, 1, 0, 0, 1};
        s_tab[16] = '{24,  1'b0, 11'd24, 11'd10, 1, 1, 1, 0, 0, 0};
        s_tab[17] = '{1,   1'b0, 11'd0,  11'd11, 0, 1, 1, 1, 0, 1};
        s_tab[18] = '{49,  1'b0, 11'd24, 11'd12, 1, 1, 1, 1, 0, 0};
        s_tab[19] = '{1,   1'b0, 11'd0,  11'd0,  0, 0, 1, 1, 1, 1};
        s_tab[20] = '{1,   1'b0, 11'd1,  11'd0,  0, 0, 1, 1, 0, 0};

        rst_s = 1'b1;
        rst_d = 1'b1;

        for (int i = 0; i < 11; i++) begin
            #1 rst_d = d_tab[i].rst;
            repeat (d_tab[i].n) @(posedge pclk);
            #1;
            $display("d_vec %0d: rst=%0b hc=%0d vc=%0d word=%h", i, d_tab[i].rst,
                     d_if.vga_out.hcount, d_if.vga_out.vcount, d_word());
            check_word($sformatf("d_vec%0d", i), d_word(), vec_word(d_tab[i]));
        end
        check_word("s_held_in_reset", s_word(), model_s(0));

        for (int i = 0; i < 21; i++) begin
            #1 rst_s = s_tab[i].rst;
            repeat (s_tab[i].n) @(posedge pclk);
            #1;
            $display("s_vec %0d: rst=%0b hc=%0d vc=%0d word=%h", i, s_tab[i].rst,
                     s_if.vga_out.hcount, s_if.vga_out.vcount, s_word());
            check_word($sformatf("s_vec%0d", i), s_word(), vec_word(s_tab[i]));
        end

        // Apply reset for one cycle in the middle of the frame, at (12,5).
        repeat (136) @(posedge pclk);
        #1;
        $display("mid_frame: hc=%0d vc=%0d", s_if.vga_out.hcount, s_if.vga_out.vcount);
        check_word("mid_frame_pos", s_word(), model_s(137));
        rst_s = 1'b1;
        @(posedge pclk);
        #1;
        $display("mid_reset: hc=%0d vc=%0d", s_if.vga_out.hcount, s_if.vga_out.vcount);
        check_word("mid_reset_state", s_word(), model_s(0));
        rst_s = 1'b0;
        @(posedge pclk);
        #1;
        $display("mid_release: hc=%0d vc=%0d", s_if.vga_out.hcount, s_if.vga_out.vcount);
        check_word("mid_release", s_word(), model_s(1));

        // Check every cycle of a full frame: outputs, rgb=0 and the delayed copy.
        sweep_err = 0; pipe_err = 0; rgb_err = 0; bad_p = -1;
        for (int p = 2; p <= 330; p++) begin
            @(posedge pclk);
            #1;
            exp_now  = model_s(p);
            exp_prev = model_s(p - 1);
            if (s_word() !== exp_now) begin
                sweep_err++;
                if (bad_p < 0) bad_p = p;
            end
            if (pipe_bus !== vga_bus_t'(exp_prev[39:2])) pipe_err++;
            if (s_if.vga_out.rgb !== 12'h000) rgb_err++;
        end
        $display("frame_sweep: mismatches=%0d first_bad_pos=%0d pipe_err=%0d rgb_err=%0d",
                 sweep_err, bad_p, pipe_err, rgb_err);
        check_int("frame_sweep_mismatches", sweep_err, 0);
        check_int("pipe_stage_mismatches", pipe_err, 0);
        check_int("rgb_nonzero_cycles", rgb_err, 0);

        // Count the clock edges between consecutive frame_start pulses.
        cnt = 0;
        while (!s_if.frame_start && cnt < 1000) begin
            @(posedge pclk);
            #1;
            cnt++;
        end
        check_int("frame_start_seen", s_if.frame_start ? 1 : 0, 1);
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(posedge pclk);
                #1;
                cnt++;
            end while (!s_if.frame_start && cnt < 1000);
            $display("frame_period %0d: %0d edges", k, cnt);
            check_int($sformatf("frame_period%0d", k), cnt, 325);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the VGA bus: generates 1024x768@60 timing (65 MHz pclk) and drives the packed VGA bus consumed by every draw stage downstream.
- Produces hcount, vcount, hs, vs, hblnk and vblnk, with rgb forced to 0; the first draw stage fills in colour.
- Also provides one-cycle frame_start and line_start strobes for game logic that must update between frames.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- SYNC_POL, 0, asserted level of hs/vs (0 = active-low, VESA 1024x768)

Ports:
- pclk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous reset, active-high
- vga_out  out  VGA_BUS_SIZE  packed bus {vs, hs, vblnk, hblnk, hcount[10:0], vcount[10:0], rgb[11:0]} using the shared VGA bus macros
- frame_start  out  1  high for exactly one cycle while hcount=0 and vcount=0
- line_start  out  1  high for exactly one cycle while hcount=0 (every line, including blanked lines)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock pclk.
- Derived constants: H_TOTAL = sum of the H_* parameters (default 1344); V_TOTAL = sum of the V_* parameters (default 806).
- Reset state, held while rst=1:
  - hcount=0, vcount=0, hblnk=0, vblnk=0, rgb=0
  - hs and vs at their deasserted level (~SYNC_POL)
  - frame_start=1, line_start=1, because both are a pure decode of the (0,0) state
- hcount:
  - Increments by 1 on every pclk edge with rst=0.
  - At H_TOTAL-1 it wraps to 0 and vcount advances.
- vcount:
  - Advances only on an hcount wrap.
  - At V_TOTAL-1 it wraps to 0 when hcount also wraps.
- Registered flags: every flag is registered from the next-count values, so flags and counters change on the same edge. There is zero extra latency between the counters and the flags.
  - hblnk = (hcount >= H_ACTIVE)
  - hs asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 1048..1183)
  - vblnk = (vcount >= V_ACTIVE)
  - vs asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 771..776); vs changes aligned with hcount=0
- Widths: both counters are 11 bits unsigned and never exceed the TOTAL-1 value; wrap uses an equality compare, never natural overflow.
- rgb field is constant 0.
- Reset mid-frame: the next edge with rst=1 forces the (0,0) state. The following edge with rst=0 gives hcount=1.
- Simultaneous wraps at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on the same edge, and frame_start and line_start assert together.
- No enable and no back-pressure: downstream stages are fixed-latency pipelines.

Decomposition:
- Shared VGA package/macro header holds:
  - VGA_BUS_SIZE and the bus field order
  - the default 1024x768 timing constants
  - the colour constants
- Natural sub-module: vga_axis_counter, one instance per axis. It has inputs tick, TOTAL, ACTIVE, SYNC_START and SYNC_LEN, and outputs count, blnk, sync and wrap. The horizontal instance ticks every cycle; the vertical instance ticks on the horizontal wrap.

Test Plan:
- Reset: hold rst 5 cycles, then release.
  - During reset: hcount=0, vcount=0, hs=vs=1 (deasserted, SYNC_POL=0), frame_start=1.
  - First edge after release: hcount=1, frame_start=0.
- Horizontal sweep: run one line.
  - hblnk 0→1 on the edge where hcount becomes 1024.
  - hs 1→0 at 1048 and 0→1 at 1184.
  - hcount 1343→0 with vcount 0→1 and line_start=1.
- Vertical sweep: run to line 806.
  - vblnk rises at vcount=768.
  - vs low for vcount 771..776 only.
  - vcount 805→0 at hcount wrap, with frame_start and line_start both 1 for one cycle.
- Frame period: count pclk edges between consecutive frame_start pulses = 1344*806 = 1083264 exactly, over 3 frames.
- Mid-frame reset: assert rst at (hcount=700, vcount=400) for 1 cycle → next state (0,0), then normal counting resumes with no glitch pulse on hs/vs.
- Bus check: rgb field = 0 for every cycle of a full frame; bus fields unpack correctly through a pass-through draw stage with 1-cycle delay.
